mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (CPU / debug loader) arbiter in front of an
// asynchronous 16-bit SRAM with active-low strobes.
//
// Ports
//   Clk, Reset                 clock, synchronous active-high reset
//   cpu_req/we/addr/wdata      CPU request (held until cpu_ack)
//   cpu_rdata, cpu_ack         CPU read data (last completed read), done pulse
//   dbg_*                      debug/switch-loader port, same meaning as cpu_*
//   ADDR                       memory address (0 while idle)
//   Mem_CE/UB/LB/OE/WE         active-low memory strobes
//   mem_wdata, mem_wdrive      write data and its tristate drive enable
//   mem_rdata                  read data from memory
//   busy, owner                transaction in progress, latched grant (1 = dbg)
//
// A transaction is IDLE -> SETUP -> ACCESS x WAIT_CYCLES -> DONE -> IDLE.
// Every output is a flop loaded from the next-state decode, so the memory
// strobes change cleanly on the clock edge that enters each state.
module mem_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ack,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [15:0] dbg_addr,
    input  logic [15:0] dbg_wdata,
    output logic [15:0] dbg_rdata,
    output logic        dbg_ack,
    output logic [15:0] ADDR,
    output logic        Mem_CE,
    output logic        Mem_UB,
    output logic        Mem_LB,
    output logic        Mem_OE,
    output logic        Mem_WE,
    output logic [15:0] mem_wdata,
    output logic        mem_wdrive,
    input  logic [15:0] mem_rdata,
    output logic        busy,
    output logic        owner
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 4;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    logic [1:0]    state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          we_q, we_next;
    logic [AW-1:0] addr_q, addr_next;
    logic          last_served, last_next;
    logic          owner_next;
    logic [DW-1:0] wdata_next;
    logic [DW-1:0] cpu_rdata_next, dbg_rdata_next;
    logic          grant;

    logic [AW-1:0] addr_out_next;
    logic          ce_next, oe_next, we_n_next, wdrive_next;
    logic          cpu_ack_next, dbg_ack_next, busy_next;
    logic          active_next, access_next;

    // Round-robin: a lone requester wins; on a tie the port not served last wins.
    always_comb begin
        grant = PORT_CPU;
        if (cpu_req && dbg_req) begin
            grant = ~last_served;
        end else if (dbg_req) begin
            grant = PORT_DBG;
        end
    end

    // Next-state, request latching, read capture and output decode.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        we_next        = we_q;
        addr_next      = addr_q;
        wdata_next     = mem_wdata;
        owner_next     = owner;
        last_next      = last_served;
        cpu_rdata_next = cpu_rdata;
        dbg_rdata_next = dbg_rdata;

        case (state)
            S_IDLE: begin
                if (cpu_req || dbg_req) begin
                    state_next = S_SETUP;
                    owner_next = grant;
                    last_next  = grant;
                    we_next    = (grant == PORT_DBG) ? dbg_we    : cpu_we;
                    addr_next  = (grant == PORT_DBG) ? dbg_addr  : cpu_addr;
                    wdata_next = (grant == PORT_DBG) ? dbg_wdata : cpu_wdata;
                end
            end
            S_SETUP: begin
                state_next = S_ACCESS;
                cnt_next   = CW'(WAIT_CYCLES - 1);
            end
            S_ACCESS: begin
                if (cnt == '0) begin
                    state_next = S_DONE;
                    // Last ACCESS cycle: memory data is valid at this edge.
                    if (!we_q) begin
                        if (owner == PORT_DBG) begin
                            dbg_rdata_next = mem_rdata;
                        end else begin
                            cpu_rdata_next = mem_rdata;
                        end
                    end
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        active_next   = (state_next == S_SETUP) || (state_next == S_ACCESS);
        access_next   = (state_next == S_ACCESS);
        ce_next       = ~active_next;
        oe_next       = ~(active_next && !we_next);
        we_n_next     = ~(access_next && we_next);
        wdrive_next   = access_next && we_next;
        addr_out_next = (state_next == S_IDLE) ? '0 : addr_next;
        cpu_ack_next  = (state_next == S_DONE) && (owner_next == PORT_CPU);
        dbg_ack_next  = (state_next == S_DONE) && (owner_next == PORT_DBG);
        busy_next     = (state_next != S_IDLE);
    end

    // State and registered outputs; reset aborts any transaction in flight.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            mem_wdata   <= '0;
            owner       <= PORT_CPU;
            last_served <= PORT_DBG;
            cpu_rdata   <= '0;
            dbg_rdata   <= '0;
            ADDR        <= '0;
            Mem_CE      <= 1'b1;
            Mem_UB      <= 1'b1;
            Mem_LB      <= 1'b1;
            Mem_OE      <= 1'b1;
            Mem_WE      <= 1'b1;
            mem_wdrive  <= 1'b0;
            cpu_ack     <= 1'b0;
            dbg_ack     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            we_q        <= we_next;
            addr_q      <= addr_next;
            mem_wdata   <= wdata_next;
            owner       <= owner_next;
            last_served <= last_next;
            cpu_rdata   <= cpu_rdata_next;
            dbg_rdata   <= dbg_rdata_next;
            ADDR        <= addr_out_next;
            Mem_CE      <= ce_next;
            Mem_UB      <= ce_next;
            Mem_LB      <= ce_next;
            Mem_OE      <= oe_next;
            Mem_WE      <= we_n_next;
            mem_wdrive  <= wdrive_next;
            cpu_ack     <= cpu_ack_next;
            dbg_ack     <= dbg_ack_next;
            busy        <= busy_next;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus randomized two-port
// traffic, every cycle compared against a transaction-phase reference model.
// A second instance with WAIT_CYCLES=15 checks the long-access timing.
module tb_mem_arbiter;

    localparam int W = 2;

    logic        Clk;
    logic        rst;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic [15:0] cpu_rdata, dbg_rdata;
    logic        cpu_ack, dbg_ack;
    logic [15:0] ADDR, mem_wdata, mem_rdata;
    logic        Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, mem_wdrive, busy, owner;

    // Second instance (WAIT_CYCLES = 15)
    logic        p_rst, p_cpu_req, p_dbg_req;
    logic [15:0] p_cpu_addr, p_mem_rdata;
    logic [15:0] p_cpu_rdata, p_dbg_rdata, p_ADDR, p_mem_wdata;
    logic        p_cpu_ack, p_dbg_ack;
    logic        p_CE, p_UB, p_LB, p_OE, p_WE, p_wdrive, p_busy, p_owner;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase 0 = idle, 1 = setup, 2..W+1 = access, W+2 = done.
    int          ph;
    logic        m_own, m_we, m_last;
    logic [15:0] m_addr, m_wdata, m_crd, m_drd;
    logic        e_cack, e_dack;

    mem_arbiter #(.WAIT_CYCLES(W)) u_dut (
        .Clk(Clk), .Reset(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .ADDR(ADDR), .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB),
        .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .mem_wdata(mem_wdata), .mem_wdrive(mem_wdrive),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    mem_arbiter #(.WAIT_CYCLES(15)) u_dut15 (
        .Clk(Clk), .Reset(p_rst),
        .cpu_req(p_cpu_req), .cpu_we(1'b0), .cpu_addr(p_cpu_addr), .cpu_wdata(16'h0000),
        .cpu_rdata(p_cpu_rdata), .cpu_ack(p_cpu_ack),
        .dbg_req(p_dbg_req), .dbg_we(1'b0), .dbg_addr(16'h0000), .dbg_wdata(16'h0000),
        .dbg_rdata(p_dbg_rdata), .dbg_ack(p_dbg_ack),
        .ADDR(p_ADDR), .Mem_CE(p_CE), .Mem_UB(p_UB), .Mem_LB(p_LB),
        .Mem_OE(p_OE), .Mem_WE(p_WE), .mem_wdata(p_mem_wdata), .mem_wdrive(p_wdrive),
        .mem_rdata(p_mem_rdata), .busy(p_busy), .owner(p_owner)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        if (rst) begin
            ph = 0; m_own = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
            m_last = 1'b1; m_crd = '0; m_drd = '0;
        end else if (ph == 0) begin
            if (cpu_req || dbg_req) begin
                m_own   = (cpu_req && dbg_req) ? ~m_last : dbg_req;
                m_last  = m_own;
                m_we    = m_own ? dbg_we    : cpu_we;
                m_addr  = m_own ? dbg_addr  : cpu_addr;
                m_wdata = m_own ? dbg_wdata : cpu_wdata;
                ph = 1;
            end
        end else begin
            if (ph == W + 1 && !m_we) begin
                if (m_own) m_drd = mem_rdata;
                else       m_crd = mem_rdata;
            end
            ph = (ph == W + 2) ? 0 : ph + 1;
        end
    endtask

    task automatic compare_all();
        logic act, acc, e_ce, e_oe, e_we, e_wd;
        act    = (ph >= 1) && (ph <= W + 1);
        acc    = (ph >= 2) && (ph <= W + 1);
        e_ce   = !act;
        e_oe   = !(act && !m_we);
        e_we   = !(acc && m_we);
        e_wd   = acc && m_we;
        e_cack = (ph == W + 2) && !m_own;
        e_dack = (ph == W + 2) && m_own;
        chk("ADDR", ADDR, (ph != 0) ? m_addr : 16'h0000);
        chk("strobes", 16'({Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE}),
            16'({e_ce, e_ce, e_ce, e_oe, e_we}));
        chk("oe_we_excl", 16'(!Mem_OE && !Mem_WE), 16'h0000);
        chk("wdrive", 16'(mem_wdrive), 16'(e_wd));
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("acks", 16'({cpu_ack, dbg_ack}), 16'({e_cack, e_dack}));
        chk("cpu_rdata", cpu_rdata, m_crd);
        chk("dbg_rdata", dbg_rdata, m_drd);
        chk("busy_owner", 16'({busy, owner}), 16'({ph != 0, m_own}));
    endtask

    task automatic step();
        @(posedge Clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        int ack_n;
        int ack_k[4];
        logic ack_o[4];
        int ack_cyc, oe_low;

        rst = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; mem_rdata = 0;
        p_rst = 1'b1; p_cpu_req = 0; p_dbg_req = 0; p_cpu_addr = 0; p_mem_rdata = 0;
        ph = 0; m_own = 0; m_we = 0; m_last = 1; m_addr = 0; m_wdata = 0; m_crd = 0; m_drd = 0;

        // Reset state
        step();
        step();
        chk("rst_busy", 16'(busy), 16'h0000);
        rst = 1'b0;
        step();

        // CPU read of 0x0010 returning 0xBEEF; ack at cycle 4
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010; mem_rdata = 16'hBEEF;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k <= 3) chk("rd_oe", 16'(Mem_OE), 16'h0000);
            chk("rd_ack", 16'(cpu_ack), 16'(k == 4));
            if (k == 4) cpu_req = 0;
        end
        chk("rd_cpu_rdata", cpu_rdata, 16'hBEEF);
        chk("rd_dbg_rdata", dbg_rdata, 16'h0000);

        // DBG write 0x1234 to 0x0020; WE low only in cycles 2-3
        dbg_req = 1; dbg_we = 1; dbg_addr = 16'h0020; dbg_wdata = 16'h1234;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("wr_we", 16'(Mem_WE), 16'(!(k == 2 || k == 3)));
            chk("wr_ack", 16'(dbg_ack), 16'(k == 4));
            if (k == 4) dbg_req = 0;
        end
        chk("wr_rdata", dbg_rdata, 16'h0000);

        // Both ports requesting continuously: alternate grants, acks 5 apart
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0100;
        dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0200; mem_rdata = 16'h4242;
        ack_n = 0;
        for (int k = 1; k <= 22 && ack_n < 4; k++) begin
            step();
            if (cpu_ack || dbg_ack) begin
                ack_k[ack_n] = k; ack_o[ack_n] = owner; ack_n++;
                if (ack_n == 4) begin cpu_req = 0; dbg_req = 0; end
            end
        end
        chk("rr_count", 16'(ack_n), 16'd4);
        if (ack_n == 4) begin
            chk("rr_order", 16'({ack_o[0], ack_o[1], ack_o[2], ack_o[3]}), 16'b0101);
            chk("rr_first", 16'(ack_k[0]), 16'd4);
            chk("rr_gap", 16'(ack_k[3] - ack_k[0]), 16'd15);
        end
        step();

        // Reset in the first ACCESS cycle of a CPU read aborts it
        rst = 1; step(); step(); rst = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0030; mem_rdata = 16'h7777;
        step(); step();
        rst = 1; step();
        chk("abort_busy", 16'({busy, cpu_ack, Mem_CE, Mem_OE}), 16'b0011);
        chk("abort_rdata", cpu_rdata, 16'h0000);
        rst = 0; cpu_req = 0; step();

        // Address change after grant is ignored; held req restarts after one IDLE
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010; mem_rdata = 16'h1111;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 2) cpu_addr = 16'h0011;
            if (k == 4) chk("hold_addr", ADDR, 16'h0010);
            if (k == 5) chk("hold_idle", 16'(busy), 16'h0000);
            if (k == 6) chk("hold_next", ADDR, 16'h0011);
            if (k == 9) cpu_req = 0;
        end

        // Randomized two-port traffic with occasional resets
        for (int c = 0; c < 600; c++) begin
            if (cpu_req && e_cack) cpu_req = ($urandom % 3 == 0);
            else if (!cpu_req)     cpu_req = ($urandom % 4 == 0);
            if (dbg_req && e_dack) dbg_req = ($urandom % 3 == 0);
            else if (!dbg_req)     dbg_req = ($urandom % 4 == 0);
            cpu_we = 1'($urandom); cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom);
            dbg_we = 1'($urandom); dbg_addr = 16'($urandom); dbg_wdata = 16'($urandom);
            mem_rdata = 16'($urandom);
            rst = ($urandom % 60 == 0);
            step();
        end
        rst = 0; cpu_req = 0; dbg_req = 0;

        // WAIT_CYCLES = 15: ACCESS lasts 15 cycles, ack at cycle 17
        @(posedge Clk); #1;
        p_rst = 0; p_cpu_req = 1; p_cpu_addr = 16'h0042; p_mem_rdata = 16'h5A5A;
        ack_cyc = 0; oe_low = 0;
        for (int k = 1; k <= 40 && ack_cyc == 0; k++) begin
            @(posedge Clk); #1;
            if (!p_OE) oe_low++;
            if (p_cpu_ack) begin ack_cyc = k; p_cpu_req = 0; end
        end
        chk("w15_ack_cycle", 16'(ack_cyc), 16'd17);
        chk("w15_oe_cycles", 16'(oe_low), 16'd16);
        chk("w15_rdata", p_cpu_rdata, 16'h5A5A);
        chk("w15_dbg_rdata", p_dbg_rdata, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
